bcd_countdown: RTL and testbench

Four-digit BCD down-counter for the reaction timer's randomized pre-light delay. It loads a 0000–9999 BCD value and decrements it once every TICK_DIV cycles of clk1k. When the count reaches 0000 it pulses `done`, which tells the timer to light the LED and start the BCD count-up. It is the decrementing counterpart to the count-up stage and drives the same digit-output format.

---
 rtl/reaction_timer_pkg.sv | 19 +
 rtl/bcd_digit_dec.sv | 28 ++
 rtl/bcd_countdown.sv | 132 +++++++++++++
 tb/tb_bcd_countdown.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer BCD counters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reaction_timer_pkg;

  localparam int          DIGIT_W      = 4;
  localparam logic [3:0]  BCD_MAX      = 4'd9;
  localparam int          TICK_DIV_MAX = 1023;
  // Divider must hold values up to TICK_DIV_MAX-1.
  localparam int          DIV_W        = $clog2(TICK_DIV_MAX + 1);

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrement stage for a borrow chain.
// Latency: combinational.
// Backpressure: none; decrements only when borrow_in is high.
// Ports: digit (current value), borrow_in (decrement request),
//        digit_nxt (decremented or unchanged value), borrow_out (wrapped 0->9).
module bcd_digit_dec
  import reaction_timer_pkg::*;
(
  input  digit_t digit,
  input  logic   borrow_in,
  output digit_t digit_nxt,
  output logic   borrow_out
);

  always_comb begin
    digit_nxt  = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == '0) begin
        digit_nxt  = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_nxt  = digit - digit_t'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_countdown.sv
// Four-digit BCD down-counter; pulses done when the count reaches 0000.
// Latency: load/start take effect one edge later; one decrement per TICK_DIV cycles.
// Backpressure: hold freezes divider and count in RUN; load/start ignored while busy.
// Ports: clk1k, rst (sync, active-high), load/load_val, start, hold, abort,
//        BCD0..BCD3 (registered digits), busy, done (1-cycle pulse), err.
module bcd_countdown
  import reaction_timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk1k,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        hold,
  input  logic        abort,
  output logic [3:0]  BCD0,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD3,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t            state_q, state_d;
  digit_t [3:0]      digits_q, digits_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  digit_t [3:0]      dec_digits;
  logic   [4:0]      borrow;
  logic              load_ok;
  logic              tick;

  assign load_ok = (load_val[3:0]   <= BCD_MAX) && (load_val[7:4]   <= BCD_MAX) &&
                   (load_val[11:8]  <= BCD_MAX) && (load_val[15:12] <= BCD_MAX);

  // abort and hold both suppress the tick, so a same-cycle abort never yields done.
  assign tick      = (state_q == RUN) && !abort && !hold && (div_q == DIV_LAST);
  assign borrow[0] = tick;

  for (genvar i = 0; i < 4; i++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit      (digits_q[i]),
      .borrow_in  (borrow[i]),
      .digit_nxt  (dec_digits[i]),
      .borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    div_d    = div_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (abort) begin
          digits_d = '0;
        end else if (load) begin
          if (load_ok) begin
            digits_d = load_val;
            err_d    = 1'b0;
          end else begin
            err_d    = 1'b1;
          end
        end else if (start && !err_q) begin
          if (digits_q == '0) begin
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            div_d   = '0;
          end
        end
      end
      RUN: begin
        if (abort) begin
          digits_d = '0;
          div_d    = '0;
          state_d  = IDLE;
        end else if (!hold) begin
          if (tick) begin
            div_d = '0;
            // A borrow out of the top digit would mean wrapping past 0000;
            // that count is terminal, so never apply such a result.
            if (!borrow[4]) begin
              digits_d = dec_digits;
              if (dec_digits == '0) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1k) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      div_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      div_q    <= div_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign BCD0 = digits_q[0];
  assign BCD1 = digits_q[1];
  assign BCD2 = digits_q[2];
  assign BCD3 = digits_q[3];
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: table vectors, corner-case sequences and random
// stimulus, with an integer-count reference model for TICK_DIV=1 and TICK_DIV=4.
module tb_bcd_countdown;

  logic        clk1k = 1'b0;
  logic        rst = 1'b1, load = 1'b0, start = 1'b0, hold = 1'b0, abort = 1'b0;
  logic [15:0] load_val = '0;

  wire [15:0] a_dig, b_dig;
  wire        a_busy, a_done, a_err, b_busy, b_done, b_err;

  always #5 clk1k = ~clk1k;

  bcd_countdown #(.TICK_DIV(1)) dut_a (
    .clk1k(clk1k), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .hold(hold), .abort(abort), .BCD0(a_dig[3:0]), .BCD1(a_dig[7:4]),
    .BCD2(a_dig[11:8]), .BCD3(a_dig[15:12]), .busy(a_busy), .done(a_done), .err(a_err));

  bcd_countdown #(.TICK_DIV(4)) dut_b (
    .clk1k(clk1k), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .hold(hold), .abort(abort), .BCD0(b_dig[3:0]), .BCD1(b_dig[7:4]),
    .BCD2(b_dig[11:8]), .BCD3(b_dig[15:12]), .busy(b_busy), .done(b_done), .err(b_err));

  int checks = 0;
  int failures = 0;

  // Reference model: the count is a plain integer 0..9999.
  int tick_div[2] = '{1, 4};
  int m_cnt[2], m_div[2];
  bit m_run[2], m_done[2], m_err[2];

  function automatic bit bcd_ok(logic [15:0] v);
    for (int i = 0; i < 4; i++) if (((v >> (4 * i)) & 16'hF) > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(logic [15:0] v);
    return ((v >> 12) & 15) * 1000 + ((v >> 8) & 15) * 100 + ((v >> 4) & 15) * 10 + (v & 15);
  endfunction

  function automatic logic [15:0] int2bcd(int n);
    return 16'((n / 1000) % 10 << 12 | (n / 100) % 10 << 8 | (n / 10) % 10 << 4 | n % 10);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(int k);
    m_done[k] = 1'b0;
    if (rst) begin
      m_cnt[k] = 0; m_div[k] = 0; m_run[k] = 1'b0; m_err[k] = 1'b0;
    end else if (!m_run[k]) begin
      if (abort) m_cnt[k] = 0;
      else if (load) begin
        if (bcd_ok(load_val)) begin m_cnt[k] = bcd2int(load_val); m_err[k] = 1'b0; end
        else m_err[k] = 1'b1;
      end else if (start && !m_err[k]) begin
        if (m_cnt[k] == 0) m_done[k] = 1'b1;
        else begin m_run[k] = 1'b1; m_div[k] = 0; end
      end
    end else if (abort) begin
      m_cnt[k] = 0; m_div[k] = 0; m_run[k] = 1'b0;
    end else if (!hold) begin
      m_div[k]++;
      if (m_div[k] == tick_div[k]) begin
        m_div[k] = 0;
        m_cnt[k]--;
        if (m_cnt[k] == 0) begin m_done[k] = 1'b1; m_run[k] = 1'b0; end
      end
    end
  endtask

  task automatic compare_model();
    check("a_digits", a_dig, int2bcd(m_cnt[0]));
    check("a_busy", a_busy, m_run[0]);
    check("a_done", a_done, m_done[0]);
    check("a_err", a_err, m_err[0]);
    check("b_digits", b_dig, int2bcd(m_cnt[1]));
    check("b_busy", b_busy, m_run[1]);
    check("b_done", b_done, m_done[1]);
    check("b_err", b_err, m_err[1]);
  endtask

  // One clock: inputs held across the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk1k);
    model_step(0);
    model_step(1);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; load = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1'b1; step(); rst = 1'b0;
  endtask

  typedef struct {
    logic        load;
    logic [15:0] val;
    logic        start;
    logic [15:0] exp_dig;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int cyc;

    vecs[0]  = '{1'b1, 16'h0005, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h0042, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h00A3, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 16'h0002, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 16'h9999, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};

    // Reset state
    do_reset();
    check("rst_digits", a_dig, 16'h0000);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);

    // Table vectors, checked on the TICK_DIV=1 instance
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      load = vecs[i].load; load_val = vecs[i].val; start = vecs[i].start;
      step();
      check($sformatf("vec%0d_digits", i), a_dig, vecs[i].exp_dig);
      check($sformatf("vec%0d_busy", i), a_busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_done", i), a_done, vecs[i].exp_done);
      check($sformatf("vec%0d_err", i), a_err, vecs[i].exp_err);
    end

    // 1000: first tick borrows across three digits, done after 1000 ticks
    do_reset();
    load = 1'b1; load_val = 16'h1000; step();
    idle_inputs(); start = 1'b1; step();
    idle_inputs(); step();
    check("k1000_first_tick", a_dig, 16'h0999);
    cyc = 1;
    while (!a_done && cyc < 1100) begin step(); cyc++; end
    check("k1000_done_cycle", cyc, 1000);

    // TICK_DIV=4, count 3, hold for 5 cycles mid-run: done at 12+5
    do_reset();
    load = 1'b1; load_val = 16'h0003; step();
    idle_inputs(); start = 1'b1; step();
    idle_inputs();
    cyc = 0;
    while (!b_done && cyc < 60) begin
      hold = (cyc >= 2 && cyc < 7);
      step();
      cyc++;
    end
    check("hold_done_cycle", cyc, 17);
    hold = 1'b0;

    // abort on the terminal decrement cycle: no done
    do_reset();
    load = 1'b1; load_val = 16'h0002; step();
    idle_inputs(); start = 1'b1; step();
    idle_inputs(); step();
    check("abort_pre_digits", a_dig, 16'h0001);
    abort = 1'b1; step();
    check("abort_digits", a_dig, 16'h0000);
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    abort = 1'b0; step();
    check("abort_done_after", a_done, 0);

    // rst mid-run
    do_reset();
    load = 1'b1; load_val = 16'h0050; step();
    idle_inputs(); start = 1'b1; step();
    idle_inputs(); step(); step(); step();
    check("midrun_digits", a_dig, 16'h0047);
    rst = 1'b1; step();
    check("midrst_digits", a_dig, 16'h0000);
    check("midrst_busy", a_busy, 0);
    check("midrst_b_busy", b_busy, 0);
    check("midrst_done", a_done, 0);
    rst = 1'b0;

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      idle_inputs();
      rst   = ($urandom_range(0, 499) == 0);
      load  = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) load_val = 16'($urandom);
      else load_val = int2bcd($urandom_range(0, 40));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
